// File: rtl/single_ifetch_pkg.sv
// Shared definitions for the single_ifetch instruction-fetch reader:
// FSM encoding, default sentinel/NOP words and the timeout counter width helper.
package single_ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

  // Bits needed to count 0..limit-1; never narrower than one bit.
  function automatic int timeout_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/single_ifetch_timeout.sv
// Wait-cycle counter for single_ifetch; exists only when FETCH_TIMEOUT_EN is defined.
// expired is high during the LIMIT-th consecutive enabled cycle after a clear.
`ifdef FETCH_TIMEOUT_EN
module ifetch_timeout
  import single_ifetch_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timeout_width(LIMIT);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/single_ifetch.sv
// Instruction-fetch reader: samples pc, runs a req/ready memory read and holds the word for decode.
// Optional wait-state timeout abort is enabled by defining FETCH_TIMEOUT_EN.
module single_ifetch
  import single_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_hold,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("single_ifetch: TIMEOUT must be at least 2");
  end

  state_t      state, state_d;
  logic        drop, drop_d;
  logic        mem_req_d, valid_d, err_d;
  logic [31:0] addr_d, inst_d, inst_pc_d;
  logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  ifetch_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != WAIT),
    .enable  (state == WAIT),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // The decoder can only release the PC on the cycle it actually takes the word.
  assign pc_hold = ~((state == HOLD) && inst_ready && !flush);

  always_comb begin
    state_d   = state;
    drop_d    = drop;
    mem_req_d = mem_req;
    addr_d    = mem_addr;
    inst_d    = inst;
    inst_pc_d = inst_pc;
    valid_d   = inst_valid;
    err_d     = fetch_err;
    unique case (state)
      IDLE: begin
        if (pc != RESET_PC && !flush) begin
          if (pc[1:0] != 2'b00) begin
            state_d   = HOLD;
            inst_d    = NOP_INST;
            inst_pc_d = pc;
            valid_d   = 1'b1;
            err_d     = 1'b1;
          end else begin
            state_d   = WAIT;
            mem_req_d = 1'b1;
            addr_d    = pc;
          end
        end
      end
      WAIT: begin
        // A request cannot be withdrawn, so a flush only marks the eventual data as stale.
        if (mem_ready || timeout_hit) begin
          mem_req_d = 1'b0;
          if (drop || flush) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d   = HOLD;
            inst_d    = mem_ready ? mem_rdata : NOP_INST;
            inst_pc_d = mem_addr;
            valid_d   = 1'b1;
            err_d     = !mem_ready;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          err_d   = 1'b0;
        end else if (inst_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_d;
      drop       <= drop_d;
      mem_req    <= mem_req_d;
      mem_addr   <= addr_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= valid_d;
      fetch_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_single_ifetch.sv
// Directed self-checking bench for single_ifetch (default parameters).
// Timeout expectations apply only when FETCH_TIMEOUT_EN is defined.
module tb_single_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        pc_hold;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  single_ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .pc_hold    (pc_hold),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'hFFFF_FFFF; flush = 0; mem_ready = 0; mem_rdata = 0; inst_ready = 0;
    step(); step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", inst); end
    total++; if (inst_pc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_inst_pc got=%h want=ffffffff", inst_pc); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", fetch_err); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc_hold !== 1'b1) begin
        bad++; $display("FAIL sentinel_idle c%0d got req=%b valid=%b hold=%b want 0/0/1", i, mem_req, inst_valid, pc_hold);
      end
    end
  endtask

  task automatic test_zero_wait();
    pc = 32'h4; mem_ready = 1; mem_rdata = 32'h2008_0005; inst_ready = 1;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin bad++; $display("FAIL zw_req got req=%b addr=%h want 1/4", mem_req, mem_addr); end
    total++; if (pc_hold !== 1'b1) begin bad++; $display("FAIL zw_hold_wait got=%b want=1", pc_hold); end
    step();
    mem_ready = 0; pc = 32'hFFFF_FFFF;
    #1;
    total++; if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 || inst_pc !== 32'h4) begin
      bad++; $display("FAIL zw_inst got v=%b inst=%h pc=%h want 1/20080005/4", inst_valid, inst, inst_pc);
    end
    total++; if (mem_req !== 1'b0 || fetch_err !== 1'b0) begin bad++; $display("FAIL zw_req_drop got req=%b err=%b want 0/0", mem_req, fetch_err); end
    total++; if (pc_hold !== 1'b0) begin bad++; $display("FAIL zw_hold_accept got=%b want=0", pc_hold); end
    step();
    total++; if (inst_valid !== 1'b0 || pc_hold !== 1'b1) begin bad++; $display("FAIL zw_after got v=%b hold=%b want 0/1", inst_valid, pc_hold); end
    inst_ready = 0;
  endtask

  task automatic test_slow_mem_and_stall();
    pc = 32'h10; mem_ready = 0; mem_rdata = 32'hDEAD_BEEF; inst_ready = 0;
    step();
    pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || inst_valid !== 1'b0) begin
        bad++; $display("FAIL slow_wait c%0d got req=%b addr=%h v=%b want 1/10/0", i, mem_req, mem_addr, inst_valid);
      end
      mem_rdata = 32'h1111_0000 + i;
      step();
    end
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ready = 0; mem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      total++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_F00D || inst_pc !== 32'h10 || pc_hold !== 1'b1 || mem_req !== 1'b0) begin
        bad++; $display("FAIL slow_hold c%0d got v=%b inst=%h pc=%h hold=%b req=%b want 1/cafef00d/10/1/0", i, inst_valid, inst, inst_pc, pc_hold, mem_req);
      end
      step();
    end
    inst_ready = 1;
    #1;
    total++; if (pc_hold !== 1'b0) begin bad++; $display("FAIL slow_accept_hold got=%b want=0", pc_hold); end
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL slow_after got=%b want=0", inst_valid); end
    inst_ready = 0;
  endtask

  task automatic test_flush();
    pc = 32'h20; mem_ready = 0; mem_rdata = 32'h5555_AAAA;
    step();
    pc = 32'hFFFF_FFFF;
    step();
    flush = 1;
    step();
    flush = 0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin bad++; $display("FAIL flush_req_held got req=%b addr=%h want 1/20", mem_req, mem_addr); end
    step();
    total++; if (mem_req !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL flush_wait got req=%b v=%b want 1/0", mem_req, inst_valid); end
    mem_ready = 1;
    step();
    mem_ready = 0;
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got req=%b v=%b want 0/0", mem_req, inst_valid); end
    step();
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL flush_idle got req=%b v=%b want 0/0", mem_req, inst_valid); end
    pc = 32'h24; mem_ready = 1; mem_rdata = 32'h1234_5678;
    step();
    pc = 32'hFFFF_FFFF;
    step();
    mem_ready = 0;
    total++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678) begin bad++; $display("FAIL flush_hold_setup got v=%b inst=%h want 1/12345678", inst_valid, inst); end
    flush = 1; inst_ready = 1;
    #1;
    total++; if (pc_hold !== 1'b1) begin bad++; $display("FAIL flush_hold_pc_hold got=%b want=1", pc_hold); end
    step();
    flush = 0; inst_ready = 0;
    total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL flush_hold_clear got v=%b inst=%h err=%b want 0/0/0", inst_valid, inst, fetch_err);
    end
  endtask

  task automatic test_misaligned();
    pc = 32'h6;
    step();
    pc = 32'hFFFF_FFFF;
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0 || fetch_err !== 1'b1 || inst_pc !== 32'h6) begin
      bad++; $display("FAIL misalign got req=%b v=%b inst=%h err=%b pc=%h want 0/1/0/1/6", mem_req, inst_valid, inst, fetch_err, inst_pc);
    end
    inst_ready = 1;
    step();
    inst_ready = 0;
    total++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL misalign_after got v=%b req=%b want 0/0", inst_valid, mem_req); end
  endtask

  task automatic test_timeout_and_async_reset();
    pc = 32'h40; mem_ready = 0;
    step();
    pc = 32'hFFFF_FFFF;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    total++; if (mem_req !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL to_wait16 got req=%b v=%b want 1/0", mem_req, inst_valid); end
    step();
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h40) begin
      bad++; $display("FAIL to_abort got req=%b v=%b err=%b inst=%h pc=%h want 0/1/1/0/40", mem_req, inst_valid, fetch_err, inst, inst_pc);
    end
    inst_ready = 1;
    step();
    inst_ready = 0;
`else
    for (int i = 0; i < 20; i++) step();
    total++; if (mem_req !== 1'b1 || inst_valid !== 1'b0 || mem_addr !== 32'h40) begin
      bad++; $display("FAIL no_to_wait got req=%b v=%b addr=%h want 1/0/40", mem_req, inst_valid, mem_addr);
    end
    mem_ready = 1;
    step();
    mem_ready = 0;
    inst_ready = 1;
    step();
    inst_ready = 0;
`endif
    pc = 32'h50;
    step();
    pc = 32'hFFFF_FFFF;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_setup got=%b want=1", mem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL arst_drop got req=%b addr=%h want 0/0", mem_req, mem_addr); end
    step();
    rst = 1'b0;
    step();
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL arst_after got req=%b v=%b want 0/0", mem_req, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_mem_and_stall();
    test_flush();
    test_misaligned();
    test_timeout_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
